fmul_param_pipe: RTL and testbench

FMUL_PARAM_PIPE -- requirements
Module: fmul_param_pipe

---
 rtl/fmul_param_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_fmul_param_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_param_pipe.sv
// fmul_param_pipe: 3-stage parameterised floating-point multiplier.
// S1 unpacks and classifies, S2 forms the mantissa product, S3 normalises,
// rounds (RNE or RTZ), handles exceptions and packs the result.
// Define FMUL_PARAM_PIPE_FLAGS_EN to build the exception flag pipeline;
// without it oDATA_FLAGS is tied to zero.
module fmul_param_pipe #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned FRACT_W = 27,
  parameter int unsigned W       = 1 + EXP_W + FRACT_W
) (
  input  logic         iCLOCK,
  input  logic         inRESET,
  input  logic         iDATA_REQ,
  output logic         oDATA_BUSY,
  input  logic         iDATA_ROUND,
  input  logic [W-1:0] iDATA_A,
  input  logic [W-1:0] iDATA_B,
  output logic         oDATA_VALID,
  input  logic         iDATA_BUSY,
  output logic [W-1:0] oDATA,
  output logic [3:0]   oDATA_FLAGS
);

  localparam int unsigned MW = FRACT_W + 1;  // mantissa with hidden bit
  localparam int unsigned PW = 2 * MW;       // product width
  localparam int unsigned XW = EXP_W + 2;    // signed exponent width

  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

  // Handshake: a stage advances when it is empty or its successor advances.
  logic r1_valid, r2_valid, r3_valid;
  logic w_adv1, w_adv2, w_adv3;

  assign w_adv3      = ~r3_valid | ~iDATA_BUSY;
  assign w_adv2      = ~r2_valid | w_adv3;
  assign w_adv1      = ~r1_valid | w_adv2;
  assign oDATA_BUSY  = ~w_adv1;
  assign oDATA_VALID = r3_valid;

  // ---------------- S1: unpack and classify ----------------
  logic               w_sa, w_sb;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [FRACT_W-1:0] w_fa, w_fb;
  logic [XW-1:0]      w_exp_sum;
  cls_e               w_cls;

  assign {w_sa, w_ea, w_fa} = iDATA_A;
  assign {w_sb, w_eb, w_fb} = iDATA_B;
  assign w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

  // Combine the operand classes; NaN and 0 x Inf dominate, then Inf, then zero.
  always_comb begin
    logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    a_max  = &w_ea;
    b_max  = &w_eb;
    a_zero = ~|w_ea;
    b_zero = ~|w_eb;
    a_nan  = a_max & |w_fa;
    b_nan  = b_max & |w_fb;
    a_inf  = a_max & ~|w_fa;
    b_inf  = b_max & ~|w_fb;
    w_cls  = ClsNorm;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) w_cls = ClsNan;
    else if (a_inf | b_inf)                                  w_cls = ClsInf;
    else if (a_zero | b_zero)                                w_cls = ClsZero;
  end

  logic            r1_sign, r1_round;
  logic [XW-1:0]   r1_exp;
  logic [MW-1:0]   r1_ma, r1_mb;
  cls_e            r1_cls;

  // S1 datapath register, loaded on an accepted request.
  always_ff @(posedge iCLOCK) begin
    if (w_adv1 & iDATA_REQ) begin
      r1_sign  <= w_sa ^ w_sb;
      r1_round <= iDATA_ROUND;
      r1_exp   <= w_exp_sum;
      r1_ma    <= {1'b1, w_fa};
      r1_mb    <= {1'b1, w_fb};
      r1_cls   <= w_cls;
    end
  end

  // ---------------- S2: mantissa product ----------------
  logic          r2_sign, r2_round;
  logic [XW-1:0] r2_exp;
  logic [PW-1:0] r2_prod;
  cls_e          r2_cls;

  // S2 datapath register.
  always_ff @(posedge iCLOCK) begin
    if (w_adv2 & r1_valid) begin
      r2_sign  <= r1_sign;
      r2_round <= r1_round;
      r2_exp   <= r1_exp;
      r2_prod  <= {{MW{1'b0}}, r1_ma} * {{MW{1'b0}}, r1_mb};
      r2_cls   <= r1_cls;
    end
  end

  // Stage-valid pipeline with synchronous reset.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else begin
      if (w_adv1) r1_valid <= iDATA_REQ;
      if (w_adv2) r2_valid <= r1_valid;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic               w_hi;
  logic [PW-2:0]      w_norm;    // product below the hidden bit
  logic [FRACT_W-1:0] w_frac, w_frac_r;
  logic               w_guard, w_sticky, w_inc, w_carry;
  logic [XW-1:0]      w_exp_f;
  logic               w_uflow, w_oflow;
  logic [W-1:0]       w_data;

  assign w_hi     = r2_prod[PW-1];
  assign w_norm   = w_hi ? r2_prod[PW-2:0] : {r2_prod[PW-3:0], 1'b0};
  assign w_frac   = w_norm[PW-2 -: FRACT_W];
  assign w_guard  = w_norm[MW-1];
  assign w_sticky = |w_norm[MW-2:0];
  assign w_inc    = ~r2_round & w_guard & (w_sticky | w_frac[0]);
  // A carry out of the fraction leaves it all-zero: mantissa becomes 1.0, exp+1.
  assign {w_carry, w_frac_r} = {1'b0, w_frac} + {{FRACT_W{1'b0}}, w_inc};
  assign w_exp_f  = r2_exp + {{(XW-1){1'b0}}, w_hi} + {{(XW-1){1'b0}}, w_carry};
  assign w_uflow  = w_exp_f[XW-1] | (w_exp_f == '0);
  assign w_oflow  = ~w_exp_f[XW-1] & (w_exp_f >= EMAX);

  // Result packing including special cases, flush-to-zero and overflow.
  always_comb begin
    w_data = '0;
    case (r2_cls)
      ClsNan:  w_data = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRACT_W-1){1'b0}}};
      ClsInf:  w_data = {r2_sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
      ClsZero: w_data = {r2_sign, {(W-1){1'b0}}};
      default: begin
        if (w_uflow)
          w_data = {r2_sign, {(W-1){1'b0}}};
        else if (w_oflow)
          w_data = r2_round ? {r2_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRACT_W{1'b1}}}
                            : {r2_sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
        else
          w_data = {r2_sign, w_exp_f[EXP_W-1:0], w_frac_r};
      end
    endcase
  end

  logic [W-1:0] r3_data;

  // Output register; holds while stalled, cleared by reset.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      r3_valid <= 1'b0;
      r3_data  <= '0;
    end else if (w_adv3) begin
      r3_valid <= r2_valid;
      if (r2_valid) r3_data <= w_data;
    end
  end

  assign oDATA = r3_data;

`ifdef FMUL_PARAM_PIPE_FLAGS_EN
  logic [3:0] w_flags;
  logic [3:0] r3_flags;

  // Flags {invalid, overflow, underflow, inexact}.
  always_comb begin
    w_flags = 4'b0000;
    case (r2_cls)
      ClsNan:  w_flags = 4'b1000;
      ClsNorm: begin
        if (w_uflow)      w_flags = 4'b0011;
        else if (w_oflow) w_flags = 4'b0101;
        else              w_flags = {3'b000, w_guard | w_sticky};
      end
      default: w_flags = 4'b0000;
    endcase
  end

  // Flag register travels with its result.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET)                r3_flags <= 4'b0000;
    else if (w_adv3 & r2_valid)  r3_flags <= w_flags;
  end

  assign oDATA_FLAGS = r3_flags;
`else
  assign oDATA_FLAGS = 4'b0000;
`endif

endmodule

// File: tb/tb_fmul_param_pipe.sv
// Scoreboard bench for fmul_param_pipe (default parameters, 36-bit).
module tb_fmul_param_pipe;

`ifdef FMUL_PARAM_PIPE_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        inRESET;
  logic        iDATA_REQ;
  logic        oDATA_BUSY;
  logic        iDATA_ROUND;
  logic [35:0] iDATA_A;
  logic [35:0] iDATA_B;
  logic        oDATA_VALID;
  logic        iDATA_BUSY;
  logic [35:0] oDATA;
  logic [3:0]  oDATA_FLAGS;

  fmul_param_pipe dut (
    .iCLOCK      (clk),
    .inRESET     (inRESET),
    .iDATA_REQ   (iDATA_REQ),
    .oDATA_BUSY  (oDATA_BUSY),
    .iDATA_ROUND (iDATA_ROUND),
    .iDATA_A     (iDATA_A),
    .iDATA_B     (iDATA_B),
    .oDATA_VALID (oDATA_VALID),
    .iDATA_BUSY  (iDATA_BUSY),
    .oDATA       (oDATA),
    .oDATA_FLAGS (oDATA_FLAGS)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] data;
    logic [3:0]  flags;
    int          t;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compare every consumed result against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (inRESET && oDATA_VALID && !iDATA_BUSY) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, required no result (cycle %0d)", oDATA, cyc);
      end else begin
        e = q.pop_front();
        chk("data", oDATA, e.data);
        chk("flags", 36'(oDATA_FLAGS), 36'(e.flags));
        if (e.lat) chk("latency", 36'(cyc - e.t), 36'd3);
      end
    end
  end

  // Present one request and push its expected result once it is accepted.
  task automatic issue(input logic [35:0] a, input logic [35:0] b, input logic rnd,
                       input logic [35:0] ed, input logic [3:0] ef, input bit lat);
    bit   done;
    exp_t e;
    done        = 1'b0;
    iDATA_REQ   = 1'b1;
    iDATA_A     = a;
    iDATA_B     = b;
    iDATA_ROUND = rnd;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!oDATA_BUSY) begin
        e.data  = ed;
        e.flags = FE ? ef : 4'h0;
        e.t     = cyc;
        e.lat   = lat;
        q.push_back(e);
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got busy, required acceptance of %h x %h", a, b);
    end
  endtask

  task automatic idle(input int n);
    iDATA_REQ = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 36'(q.size()), 36'd0);
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_valid", 36'(oDATA_VALID), 36'd0);
    chk("rst_data", oDATA, 36'h0);
    chk("rst_flags", 36'(oDATA_FLAGS), 36'd0);
    chk("rst_busy", 36'(oDATA_BUSY), 36'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    inRESET     = 1'b0;
    iDATA_REQ   = 1'b0;
    iDATA_BUSY  = 1'b0;
    iDATA_ROUND = 1'b0;
    iDATA_A     = '0;
    iDATA_B     = '0;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    inRESET = 1'b1;
    idle(2);

    // Directed vectors, back to back, unstalled: latency must be exactly 3.
    issue(36'h3F8000000, 36'h400000000, 1'b0, 36'h400000000, 4'b0000, 1'b1);
    issue(36'hBF8000000, 36'h400000000, 1'b0, 36'hC00000000, 4'b0000, 1'b1);
    issue(36'h7F7FFFFFF, 36'h400000000, 1'b0, 36'h7F8000000, 4'b0101, 1'b1);
    issue(36'h7F7FFFFFF, 36'h400000000, 1'b1, 36'h7F7FFFFFF, 4'b0101, 1'b1);
    issue(36'h7F8000000, 36'h000000000, 1'b0, 36'h7FC000000, 4'b1000, 1'b1);
    issue(36'h7F8000000, 36'hC00000000, 1'b0, 36'hFF8000000, 4'b0000, 1'b1);
    issue(36'h008000000, 36'h008000000, 1'b0, 36'h000000000, 4'b0011, 1'b1);
    issue(36'h7F8000001, 36'h3F8000000, 1'b0, 36'h7FC000000, 4'b1000, 1'b1);
    issue(36'h800000000, 36'h400000000, 1'b0, 36'h800000000, 4'b0000, 1'b1);
    issue(36'h3FC000000, 36'h3FC000000, 1'b0, 36'h401000000, 4'b0000, 1'b1);
    // Half-ulp ties: odd LSB rounds up, even LSB stays; RTZ truncates.
    issue(36'h3F8000001, 36'h3FC000000, 1'b0, 36'h3FC000002, 4'b0001, 1'b1);
    issue(36'h3F8000001, 36'h3FC000000, 1'b1, 36'h3FC000001, 4'b0001, 1'b1);
    issue(36'h3F8000003, 36'h3FC000000, 1'b0, 36'h3FC000004, 4'b0001, 1'b1);
    // Product 2 - 2^-28: RNE carries out to 2.0, RTZ gives max mantissa.
    issue(36'h3FFAF9C00, 36'h3F8290000, 1'b0, 36'h400000000, 4'b0001, 1'b1);
    issue(36'h3FFAF9C00, 36'h3F8290000, 1'b1, 36'h3FFFFFFFF, 4'b0001, 1'b1);
    issue(36'h3F8000001, 36'h3F8000001, 1'b0, 36'h3F8000002, 4'b0001, 1'b1);
    idle(1);
    drain();

    // Stall: 4 requests, hold downstream busy 5 cycles once the first is valid.
    fork
      begin
        issue(36'h3F8000000, 36'h400000000, 1'b0, 36'h400000000, 4'b0000, 1'b0);
        issue(36'h400000000, 36'h400000000, 1'b0, 36'h408000000, 4'b0000, 1'b0);
        issue(36'h3FC000000, 36'h3FC000000, 1'b0, 36'h401000000, 4'b0000, 1'b0);
        issue(36'hBF8000000, 36'hBF8000000, 1'b0, 36'h3F8000000, 4'b0000, 1'b0);
        iDATA_REQ = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(posedge clk);
          #1;
          seen = oDATA_VALID;
        end
        chk("stall_first_valid", 36'(seen), 36'd1);
        iDATA_BUSY = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_busy", 36'(oDATA_BUSY), 36'd1);
          chk("stall_valid", 36'(oDATA_VALID), 36'd1);
          chk("stall_hold", oDATA, 36'h400000000);
          @(posedge clk);
          #1;
        end
        iDATA_BUSY = 1'b0;
      end
    join
    drain();

    // Reset with three operations in flight plus a simultaneous request.
    iDATA_BUSY = 1'b1;
    issue(36'h3F8000000, 36'h400000000, 1'b0, 36'h400000000, 4'b0000, 1'b0);
    issue(36'h7F7FFFFFF, 36'h400000000, 1'b0, 36'h7F8000000, 4'b0101, 1'b0);
    issue(36'h7F8000000, 36'h000000000, 1'b0, 36'h7FC000000, 4'b1000, 1'b0);
    inRESET   = 1'b0;
    iDATA_REQ = 1'b1;
    iDATA_A   = 36'h3FC000000;
    iDATA_B   = 36'h3FC000000;
    @(posedge clk);
    #1;
    q.delete();
    inRESET    = 1'b1;
    iDATA_REQ  = 1'b0;
    iDATA_BUSY = 1'b0;
    chk_reset_outputs();
    idle(8);
    issue(36'hBF8000000, 36'h400000000, 1'b0, 36'hC00000000, 4'b0000, 1'b1);
    idle(1);
    drain();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
